blink_meter: RTL and testbench
==============================

// Module: blink_meter
// PURPOSE
//  Measures a slow, externally generated square wave (e.g. a blink/heartbeat line
//  from another board or FPGA). Reports period and high time in clk cycles, plus a
//  stall flag when the line stops toggling. Sits between an input pin and the
//  status/debug logic; it is the receiving end of a counter-driven blink output.
// PARAMETERS
//  CNT_W        26        width of period/high counters and result buses
//  TIMEOUT      33554432  cycles with no rising edge before stalled asserts (< 2**CNT_W)
//  SYNC_STAGES  2         synchronizer flops on sig_in (>= 2)
// PORTS
//  clk         in   1      system clock
//  rst         in   1      synchronous, active-high reset
//  sig_in      in   1      asynchronous square-wave input
//  out_period  out  CNT_W  cycles between consecutive rising edges
//  out_high    out  CNT_W  cycles sig was high within that period
//  out_valid   out  1      result valid; held until accepted
//  out_ready   in   1      consumer accepts result when out_valid && out_ready
//  overrun     out  1      sticky: a result was dropped while out_valid was pending
//  stalled     out  1      no rising edge seen for TIMEOUT cycles
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, sync chain 0, FSM -> WAIT_RISE.
//  - sig_s = last sync stage; sig_d = sig_s delayed 1 cycle; rise = sig_s & ~sig_d.
//  - FSM: WAIT_RISE --rise--> MEASURE (counters start). MEASURE --rise--> MEASURE,
//    publishing a result. Any state --timeout--> WAIT_RISE with stalled=1.
//  - period_cnt: loaded with 1 on rise, else +1. high_cnt: loaded with 1 on rise,
//    else +sig_s. Steady square wave H high / L low cycles -> period=H+L, high=H.
//  - Result publish: on rise in MEASURE, out_period<=period_cnt, out_high<=high_cnt,
//    out_valid<=1 on the following edge (1 cycle after rise detect).
//    First result needs two rises after reset or stall.
//  - Handshake: out_valid && out_ready clears out_valid next cycle. Data stable while
//    out_valid=1. New result while out_valid=1 and not accepted this cycle -> dropped,
//    old data kept, overrun<=1. Accept and publish same cycle -> new data loaded,
//    out_valid stays 1, no overrun.
//  - overrun clears only on reset.
//  - Timeout: idle_cnt counts cycles since last rise (reset to 0 on rise). When
//    idle_cnt reaches TIMEOUT-1: stalled<=1, FSM->WAIT_RISE, counters cleared.
//    Next rise clears stalled. Counters never wrap, as TIMEOUT < 2**CNT_W.
//  - Pending result is not discarded by a stall.
//  - Reset mid-measurement: immediate return to reset state; partial counts lost.
// STRUCTURE
//  - Shared include (blink_defs.vh): FSM state encodings (WAIT_RISE, MEASURE) and
//    default CNT_W; this is shared with the blinker/heartbeat generators.
//  - One sub-module: sync_edge (SYNC_STAGES flop chain plus rise detect, outputs
//    sig_s and rise). FSM, counters and output register stay in blink_meter.
// TESTING (bench params: TIMEOUT=100, CNT_W=16)
//  1 rst high 5 cycles, sig_in toggling -> all outputs 0 throughout reset.
//  2 square wave H=10, L=6, out_ready=1 -> after second rise, out_period=16,
//    out_high=10, out_valid 1-cycle pulses every 16 cycles, overrun=0.
//  3 same wave, out_ready=0 for 40 cycles -> first result held unchanged, overrun=1;
//    raise out_ready -> accepted, next result period=16/high=10, overrun stays 1.
//  4 sig_in held 0 after a valid result -> stalled=1 exactly 100 cycles after last
//    rise, no new out_valid; resume H=3,L=5 -> stalled clears on first rise,
//    first result period=8 high=3 on second rise.
//  5 H=1, L=1 wave -> period=2, high=1; 1-cycle glitch then idle 50 -> period=51.
//  6 rst pulse mid-period -> outputs 0, next result only after two further rises.

Source files
------------

// File: rtl/blink_meter_pkg.sv
// Shared definitions for the blink/heartbeat family: meter FSM state encodings
// and default parameter values. The meter uses the same encodings as the
// blinker/heartbeat generators so debug state reads the same across blocks.
package blink_meter_pkg;

    localparam int DEF_CNT_W       = 26;
    localparam int DEF_TIMEOUT     = 33554432;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [0:0] {
        WAIT_RISE = 1'b0,
        MEASURE   = 1'b1
    } meter_state_t;

endpackage

// File: rtl/blink_meter_sync_edge.sv
// sync_edge: brings an asynchronous input into the clk domain through a flop
// chain and flags the first synchronized cycle of each rising edge.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   i_sig       asynchronous input
//   o_sig_s     synchronized level (last chain stage)
//   o_rise      one-cycle pulse: o_sig_s high now, low the cycle before
module sync_edge
    import blink_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_sig_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sig_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_sig_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_sig_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sig_s = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_sig_d;

endmodule

// File: rtl/blink_meter.sv
// blink_meter: measures a slow external square wave. Reports the period and the
// high time (both in clk cycles) of each complete period, and flags a stall
// when no rising edge arrives for TIMEOUT cycles.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   sig_in       asynchronous square-wave input
//   out_period   cycles between the two most recent rising edges
//   out_high     cycles the line was high within that period
//   out_valid    result valid, held until accepted
//   out_ready    consumer accepts the result
//   overrun      sticky: a new result was dropped because one was still pending
//   stalled      no rising edge for TIMEOUT cycles
//   o_dbg_state  current FSM state
//
// Handshake: a result transfers on any edge where out_valid && out_ready.
// out_period/out_high never change while out_valid is high unless the pending
// result is accepted on that same edge, in which case the new result replaces
// it and out_valid stays high.
module blink_meter
    import blink_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] out_period,
    output logic [CNT_W-1:0] out_high,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             stalled,
    output meter_state_t     o_dbg_state
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic             w_sig_s;
    logic             w_rise;
    logic             w_timeout;
    logic             w_publish;
    meter_state_t     r_state;
    meter_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_idle_cnt;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (sig_in),
        .o_sig_s(w_sig_s),
        .o_rise (w_rise)
    );

    // A rise restarts the idle count, so it always wins over a timeout.
    assign w_timeout = (r_idle_cnt == IDLE_LAST) && !w_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_RISE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_publish   = 1'b0;
        case (r_state)
            WAIT_RISE: begin
                if (w_rise) w_state_nxt = MEASURE;
            end
            MEASURE: begin
                // A rise closes the running period and opens the next one.
                if (w_rise) w_publish = 1'b1;
            end
        endcase
        if (w_timeout) w_state_nxt = WAIT_RISE;
    end

    assign o_dbg_state = r_state;

    // The rise cycle itself counts as the first cycle (and first high cycle)
    // of the new period, so a steady H/L wave yields period=H+L, high=H.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
        end else if (w_rise) begin
            r_period_cnt <= ONE;
            r_high_cnt   <= ONE;
        end else if (w_timeout) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
        end else if (r_state == MEASURE) begin
            r_period_cnt <= r_period_cnt + ONE;
            r_high_cnt   <= r_high_cnt + {{(CNT_W-1){1'b0}}, w_sig_s};
        end
    end

    // Idle count saturates at TIMEOUT-1 so it cannot wrap while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
            stalled    <= 1'b0;
        end else if (w_rise) begin
            r_idle_cnt <= '0;
            stalled    <= 1'b0;
        end else begin
            if (r_idle_cnt != IDLE_LAST) r_idle_cnt <= r_idle_cnt + ONE;
            if (w_timeout) stalled <= 1'b1;
        end
    end

    // A stall leaves a pending result untouched; only the consumer clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_period <= '0;
            out_high   <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else if (w_publish && (!out_valid || out_ready)) begin
            out_period <= r_period_cnt;
            out_high   <= r_high_cnt;
            out_valid  <= 1'b1;
        end else begin
            if (w_publish) overrun <= 1'b1;
            if (out_valid && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_blink_meter.sv
module tb_blink_meter;
    import blink_meter_pkg::*;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig_in = 1'b0;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] out_period;
    logic [CNT_W-1:0] out_high;
    logic             out_valid;
    logic             overrun;
    logic             stalled;
    meter_state_t     dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ph = 0;
    int valid_cycles = 0;
    int first_stall = -1;

    // Accepted results as {period, high}, with the cycle each was accepted.
    logic [31:0] obs_q[$];
    int          acc_cyc_q[$];

    blink_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .out_period (out_period),
        .out_high   (out_high),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .stalled    (stalled),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Inputs are already set for the coming edge, so this sees exactly what
    // that edge sees: valid && ready here means the result transfers on it.
    task automatic sample();
        if (out_valid) valid_cycles++;
        if (out_valid && out_ready) begin
            obs_q.push_back({out_period, out_high});
            acc_cyc_q.push_back(cyc);
        end
    endtask

    task automatic drive_step(input logic s);
        sig_in = s;
        sample();
        step();
    endtask

    task automatic wave_steps(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            drive_step(logic'(ph < h));
            ph++;
            if (ph >= h + l) ph = 0;
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        acc_cyc_q.delete();
        valid_cycles = 0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_next(input string tag, input int p, input int h);
        logic [31:0] v;
        if (obs_q.size() > 0) v = obs_q.pop_front();
        else v = 32'hFFFF_FFFF;
        check(tag, 64'(v), 64'({p[15:0], h[15:0]}));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_period"}, 64'(out_period), 64'd0);
        check({tag, "_high"}, 64'(out_high), 64'd0);
        check({tag, "_flags"}, 64'({out_valid, overrun, stalled}), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // 1: reset held with the input toggling
        step();
        for (int i = 0; i < 5; i++) begin
            sig_in = ~sig_in;
            step();
            check_idle_outputs("rst_hold");
        end
        check("rst_state", 64'(dbg_state), 64'(WAIT_RISE));
        rst = 1'b0;
        sig_in = 1'b0;
        for (int i = 0; i < 3; i++) drive_step(1'b0);
        clear_obs();

        // 2: H=10 L=6, always ready: three results, one per 16 cycles
        out_ready = 1'b1;
        ph = 0;
        wave_steps(10, 6, 64);
        check("w16_count", 64'(obs_q.size()), 64'd3);
        check("w16_valid_cycles", 64'(valid_cycles), 64'd3);
        if (acc_cyc_q.size() == 3) begin
            check("w16_spacing0", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd16);
            check("w16_spacing1", 64'(acc_cyc_q[2] - acc_cyc_q[1]), 64'd16);
        end
        for (int i = 0; i < 3; i++) check_next("w16_result", 16, 10);
        check("w16_overrun", 64'(overrun), 64'd0);
        clear_obs();

        // 3: consumer stalls 40 cycles, then drains
        out_ready = 1'b0;
        wave_steps(10, 6, 40);
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_period", 64'(out_period), 64'd16);
        check("hold_high", 64'(out_high), 64'd10);
        check("hold_overrun", 64'(overrun), 64'd1);
        check("hold_no_accept", 64'(obs_q.size()), 64'd0);
        out_ready = 1'b1;
        wave_steps(10, 6, 40);
        check("drain_count", 64'(obs_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) check_next("drain_result", 16, 10);
        check("drain_overrun_sticky", 64'(overrun), 64'd1);
        clear_obs();

        // 4: one more high pulse, then the line stops
        for (int i = 0; i < 110; i++) begin
            if (stalled && first_stall < 0) first_stall = i;
            drive_step(logic'(i < 10));
        end
        check("stall_latency", 64'(first_stall), 64'd103);
        check("stall_flag", 64'(stalled), 64'd1);
        check("stall_state", 64'(dbg_state), 64'(WAIT_RISE));
        check("stall_valid_cycles", 64'(valid_cycles), 64'd1);
        check("stall_count", 64'(obs_q.size()), 64'd1);
        check_next("stall_last_result", 16, 10);
        clear_obs();

        // resume with H=3 L=5
        ph = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 2) check("resume_still_stalled", 64'(stalled), 64'd1);
            if (i == 3) check("resume_stall_cleared", 64'(stalled), 64'd0);
            wave_steps(3, 5, 1);
        end
        check("resume_count", 64'(obs_q.size()), 64'd2);
        for (int i = 0; i < 2; i++) check_next("resume_result", 8, 3);
        clear_obs();

        // 5: fastest wave, then a lone glitch followed by 50 idle cycles
        ph = 0;
        wave_steps(1, 1, 20);
        check("fast_count", 64'(obs_q.size()), 64'd9);
        check_next("fast_first", 8, 3);
        for (int i = 0; i < 8; i++) check_next("fast_result", 2, 1);
        clear_obs();
        for (int i = 0; i < 64; i++) drive_step(logic'(i == 0 || (i >= 51 && i <= 55)));
        check("glitch_count", 64'(obs_q.size()), 64'd3);
        check_next("glitch_tail0", 2, 1);
        check_next("glitch_tail1", 2, 1);
        check_next("glitch_period", 51, 1);
        clear_obs();
        ph = 0;
        wave_steps(10, 6, 8);
        check("after_glitch_count", 64'(obs_q.size()), 64'd1);
        check_next("after_glitch_result", 13, 5);

        // 6: reset in the middle of a high phase
        rst = 1'b1;
        wave_steps(10, 6, 2);
        check_idle_outputs("midrst");
        check("midrst_state", 64'(dbg_state), 64'(WAIT_RISE));
        rst = 1'b0;
        clear_obs();
        wave_steps(10, 6, 38);
        check("postrst_count", 64'(obs_q.size()), 64'd1);
        check("postrst_valid_cycles", 64'(valid_cycles), 64'd1);
        check_next("postrst_result", 16, 10);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
